mc_maindec: RTL and testbench
=============================

Name: mc_maindec

Overview:
- Multicycle successor to the single-cycle main decoder: a Moore control FSM that sequences each instruction over 3–5 cycles.
- Drives datapath strobes and muxes from a registered opcode/funct, and stalls on a memory-ready handshake.
- Adds a sticky-or-recoverable illegal-opcode trap and a retired-instruction counter.
- Sits between the instruction register and the multicycle datapath/memory.

Parameters:
- OP_W, 6, opcode and funct width.
- CNT_W, 32, retired-instruction counter width; wraps modulo 2^CNT_W.
- USE_MEM_READY, 1; when 0, mem_ready is ignored and treated as 1.
- TRAP_HALT, 0; when 0, TRAP returns to FETCH after one cycle; when 1, TRAP holds until reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OP_W  instr[31:26] from the IR.
- functi  in  OP_W  instr[5:0] from the IR.
- mem_ready  in  1  memory access completes this cycle.
- zero  in  1  ALU zero flag.
- pc_write  out  1  PC load enable.
- pc_write_cond  out  1  PC load if zero.
- pc_en  out  1  pc_write | (pc_write_cond & zero).
- iord  out  1  address mux: 0 = PC, 1 = ALUOut.
- ir_write  out  1  IR load.
- mem_write  out  1  memory write strobe.
- memory_to_register  out  2  00 ALUOut, 01 MDR, 10 PC (link).
- register_destination  out  2  00 rt, 01 rd, 10 reg 31.
- register_write  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- alu_operation  out  2  00 add, 01 sub, 10 funct-driven.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 A (jr).
- instr_done  out  1  one-cycle pulse on the final cycle of a retired instruction.
- illegal_op  out  1  high while in TRAP.
- instr_count  out  CNT_W  retired-instruction count.
- state_o  out  4  current state, for debug.

Behaviour:
- Reset (rst_n low, async): state = FETCH, op_q = 0, fn_q = 0, instr_count = 0.
  - pc_write, pc_write_cond, ir_write, mem_write, register_write and instr_done are forced 0 while reset is held.
  - Every other output is the FETCH decode.
- Opcodes: R 000000, LW 000001, SW 000010, ADDI 000011, SUBI 000100, BEQ 000101, J 000111, JAL 001000.
  - JR is R-type with funct 001000.
  - Any other opcode is illegal.
- Outputs are Moore decodes of the state; the only exceptions are the mem_ready gating and pc_en.
- Unlisted outputs are 0 in every state.
- FETCH:
  - Drives iord 0, alu_src_a 0, alu_src_b 01, alu_op 00, pc_source 00.
  - ir_write and pc_write equal mem_ready (gated).
  - Stays in FETCH until mem_ready; then → DECODE.
- DECODE:
  - Latches op_q/fn_q from opcode/functi.
  - Drives alu_src_a 0, alu_src_b 11, alu_op 00 (branch target into ALUOut).
  - Next state: LW/SW → MEMADR; R → JR if funct 001000, else RTEXEC; ADDI/SUBI → IMMEXEC; BEQ → BRANCH; J → JUMP; JAL → JALS; other → TRAP.
  - All later states decode op_q/fn_q, never the live inputs.
- MEMADR: alu_src_a 1, alu_src_b 10, alu_op 00. → MEMRD if LW, → MEMWR if SW.
- MEMRD: iord 1. Holds until mem_ready, then → MEMWB.
- MEMWB: register_destination 00, memory_to_register 01, register_write, instr_done. → FETCH.
- MEMWR: iord 1, mem_write held high until the mem_ready cycle inclusive; instr_done on that cycle. → FETCH.
- RTEXEC: alu_src_a 1, alu_src_b 00, alu_op 10. → ALUWB.
- ALUWB: register_destination 01, memory_to_register 00, register_write, instr_done. → FETCH.
- IMMEXEC: alu_src_a 1, alu_src_b 10, alu_op 00 for ADDI or 01 for SUBI. → IMMWB.
- IMMWB: register_destination 00, memory_to_register 00, register_write, instr_done. → FETCH.
- BRANCH: alu_src_a 1, alu_src_b 00, alu_op 01, pc_write_cond, pc_source 01, instr_done. → FETCH.
- JUMP: pc_write, pc_source 10, instr_done. → FETCH.
- JALS: pc_write, pc_source 10, register_write, register_destination 10, memory_to_register 10 (PC already holds PC+4), instr_done. → FETCH.
- JR: pc_write, pc_source 11, instr_done. → FETCH.
- TRAP:
  - illegal_op = 1, no strobes, instr_count unchanged.
  - → FETCH next cycle if TRAP_HALT = 0; otherwise stays until reset.
- Latency (mem_ready always 1): LW 5 cycles; SW, R, ADDI and SUBI 4 cycles; BEQ, J, JAL and JR 3 cycles.
- instr_count increments on every instr_done and wraps to 0 with no flag.
- Reset mid-instruction aborts immediately: no partial strobe is emitted and the count is not incremented.
- A dropped mem_ready simply extends FETCH/MEMRD/MEMWR; no timeout.
- Unused state encodings → FETCH.

Decomposition:
- Package maindec_pkg holds:
  - state_t enum (4 bits);
  - opcode and funct constants (OP_RTYPE … OP_JAL, FN_JR);
  - ALU_ADD/SUB/FUNCT, PCSRC_*, SRCB_*, M2R_* and RDST_* localparams.
- One sub-module, mc_ctrl_decode: purely combinational, state + op_q → control vector.
- mc_maindec itself keeps the state register, op/funct latches, mem_ready gating and the counter.

Test Plan:
- Reset release, mem_ready = 0 for 3 cycles then 1 → state_o stays FETCH, ir_write = pc_write = 0 until the ready cycle, then DECODE.
- LW (000001), mem_ready always 1 → exactly 5 cycles; MEMWB has register_write = 1, memory_to_register = 01, register_destination = 00; instr_count 0→1.
- R-type funct 000111 → RTEXEC alu_operation = 10, then ALUWB register_destination = 01. Funct 001000 → JR with pc_source = 11, pc_write = 1, 3 cycles total.
- BEQ with zero = 1 and then zero = 0 → pc_en = 1 and 0 respectively in BRANCH; JAL → register_destination = 10, memory_to_register = 10, register_write = 1 in a single cycle.
- Opcode 101010 → illegal_op = 1 for 1 cycle then FETCH, count unchanged (TRAP_HALT = 0); with TRAP_HALT = 1 it holds 10+ cycles until rst_n low.
- CNT_W = 4, 17 J instructions → instr_count wraps to 1. Assert rst_n low mid-MEMWR → mem_write drops immediately, state FETCH, count 0.

Source files
------------

// File: rtl/maindec_pkg.sv
// Shared types and encodings for the multicycle main decoder: FSM states,
// opcode/funct values, datapath mux selects and the packed control vector.
package maindec_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXEC  = 4'd6,
    S_ALUWB   = 4'd7,
    S_IMMEXEC = 4'd8,
    S_IMMWB   = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_JALS    = 4'd12,
    S_JR      = 4'd13,
    S_TRAP    = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b000001;
  localparam logic [5:0] OP_SW    = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b000011;
  localparam logic [5:0] OP_SUBI  = 6'b000100;
  localparam logic [5:0] OP_BEQ   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000111;
  localparam logic [5:0] OP_JAL   = 6'b001000;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_A      = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] RDST_RT  = 2'b00;
  localparam logic [1:0] RDST_RD  = 2'b01;
  localparam logic [1:0] RDST_R31 = 2'b10;

  // rdy_gate marks states whose strobes (ir_write, pc_write, instr_done)
  // only fire on the cycle memory reports ready.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic [1:0] m2r;
    logic [1:0] rdst;
    logic       reg_write;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal;
    logic       rdy_gate;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: FSM state plus latched opcode/funct -> raw control
// vector, before mem_ready gating and reset masking.
module mc_ctrl_decode
  import maindec_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  state_t          i_state,
  input  logic [OP_W-1:0] i_op,
  input  logic [OP_W-1:0] i_fn,
  output ctrl_t           o_ctrl
);

  logic w_is_jr;

  assign w_is_jr = (i_op == OP_W'(OP_RTYPE)) && (i_fn == OP_W'(FN_JR));

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.src_b    = SRCB_FOUR;
        o_ctrl.pc_write = 1'b1;
        o_ctrl.ir_write = 1'b1;
        o_ctrl.rdy_gate = 1'b1;
      end
      S_DECODE: o_ctrl.src_b = SRCB_IMMSH;
      S_MEMADR: begin
        o_ctrl.src_a = 1'b1;
        o_ctrl.src_b = SRCB_IMM;
      end
      S_MEMRD: o_ctrl.iord = 1'b1;
      S_MEMWB: begin
        o_ctrl.rdst       = RDST_RT;
        o_ctrl.m2r        = M2R_MDR;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.iord       = 1'b1;
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
        o_ctrl.rdy_gate   = 1'b1;
      end
      S_RTEXEC: begin
        o_ctrl.src_a  = 1'b1;
        o_ctrl.src_b  = SRCB_B;
        o_ctrl.alu_op = ALU_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.rdst       = RDST_RD;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_IMMEXEC: begin
        o_ctrl.src_a  = 1'b1;
        o_ctrl.src_b  = SRCB_IMM;
        o_ctrl.alu_op = (i_op == OP_W'(OP_SUBI)) ? ALU_SUB : ALU_ADD;
      end
      S_IMMWB: begin
        o_ctrl.rdst       = RDST_RT;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.src_a         = 1'b1;
        o_ctrl.src_b         = SRCB_B;
        o_ctrl.alu_op        = ALU_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_src        = PCSRC_ALUOUT;
        o_ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_src     = PCSRC_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
      S_JALS: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_src     = PCSRC_JUMP;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.rdst       = RDST_R31;
        o_ctrl.m2r        = M2R_PC;
        o_ctrl.instr_done = 1'b1;
      end
      // Register-indirect jump is qualified by the latched instruction so a
      // corrupted state register can never load the PC from A.
      S_JR: begin
        o_ctrl.pc_write   = w_is_jr;
        o_ctrl.pc_src     = w_is_jr ? PCSRC_A : PCSRC_ALU;
        o_ctrl.instr_done = w_is_jr;
      end
      S_TRAP: o_ctrl.illegal = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle main-decoder control FSM: state register, opcode/funct latches,
// memory-ready gating of strobes and a retired-instruction counter.
module mc_maindec
  import maindec_pkg::*;
#(
  parameter int OP_W          = 6,
  parameter int CNT_W         = 32,
  parameter int USE_MEM_READY = 1,
  parameter int TRAP_HALT     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  opcode,
  input  logic [OP_W-1:0]  functi,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_en,
  output logic             iord,
  output logic             ir_write,
  output logic             mem_write,
  output logic [1:0]       memory_to_register,
  output logic [1:0]       register_destination,
  output logic             register_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_operation,
  output logic [1:0]       pc_source,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state_o
);

  state_t          r_state;
  state_t          w_next;
  logic [OP_W-1:0] r_op;
  logic [OP_W-1:0] r_fn;
  logic [CNT_W-1:0] r_count;
  ctrl_t           w_ctrl;
  logic            w_rdy;
  logic            w_gate;

  assign w_rdy = (USE_MEM_READY == 0) ? 1'b1 : mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_fn    <= '0;
      r_count <= '0;
    end else begin
      if (r_state == S_DECODE) begin
        r_op <= opcode;
        r_fn <= functi;
      end
      if (instr_done) r_count <= r_count + CNT_W'(1);
    end
  end

  // DECODE dispatches on the live IR fields; later states use the latches.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = w_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OP_W'(OP_RTYPE))
          w_next = (functi == OP_W'(FN_JR)) ? S_JR : S_RTEXEC;
        else if (opcode == OP_W'(OP_LW) || opcode == OP_W'(OP_SW))
          w_next = S_MEMADR;
        else if (opcode == OP_W'(OP_ADDI) || opcode == OP_W'(OP_SUBI))
          w_next = S_IMMEXEC;
        else if (opcode == OP_W'(OP_BEQ)) w_next = S_BRANCH;
        else if (opcode == OP_W'(OP_J))   w_next = S_JUMP;
        else if (opcode == OP_W'(OP_JAL)) w_next = S_JALS;
        else                              w_next = S_TRAP;
      end
      S_MEMADR: begin
        if (r_op == OP_W'(OP_LW))      w_next = S_MEMRD;
        else if (r_op == OP_W'(OP_SW)) w_next = S_MEMWR;
        else                           w_next = S_FETCH;
      end
      S_MEMRD:   w_next = w_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_next = w_rdy ? S_FETCH : S_MEMWR;
      S_RTEXEC:  w_next = S_ALUWB;
      S_IMMEXEC: w_next = S_IMMWB;
      S_TRAP:    w_next = (TRAP_HALT != 0) ? S_TRAP : S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  mc_ctrl_decode #(.OP_W(OP_W)) u_ctrl_decode (
    .i_state (r_state),
    .i_op    (r_op),
    .i_fn    (r_fn),
    .o_ctrl  (w_ctrl)
  );

  // Strobes are masked by rst_n so an asynchronous abort emits nothing.
  always_comb begin
    w_gate               = w_ctrl.rdy_gate ? w_rdy : 1'b1;
    pc_write             = w_ctrl.pc_write & w_gate & rst_n;
    pc_write_cond        = w_ctrl.pc_write_cond & rst_n;
    ir_write             = w_ctrl.ir_write & w_gate & rst_n;
    mem_write            = w_ctrl.mem_write & rst_n;
    register_write       = w_ctrl.reg_write & rst_n;
    instr_done           = w_ctrl.instr_done & w_gate & rst_n;
    pc_en                = pc_write | (pc_write_cond & zero);
    iord                 = w_ctrl.iord;
    memory_to_register   = w_ctrl.m2r;
    register_destination = w_ctrl.rdst;
    alu_src_a            = w_ctrl.src_a;
    alu_src_b            = w_ctrl.src_b;
    alu_operation        = w_ctrl.alu_op;
    pc_source            = w_ctrl.pc_src;
    illegal_op           = w_ctrl.illegal;
    instr_count          = r_count;
    state_o              = r_state;
  end

endmodule

// File: tb/tb_mc_maindec.sv
// Self-checking bench for mc_maindec: directed vector table, randomized
// instruction stream with memory stalls, and reset/trap/wrap sequences.
module tb_mc_maindec;
  import maindec_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: default parameters
  logic        a_rst_n, a_mem_ready, a_zero;
  logic [5:0]  a_opcode, a_functi;
  logic        a_pc_write, a_pc_write_cond, a_pc_en, a_iord, a_ir_write, a_mem_write;
  logic [1:0]  a_m2r, a_rdst, a_alu_src_b, a_alu_op, a_pc_source;
  logic        a_register_write, a_alu_src_a, a_instr_done, a_illegal_op;
  logic [31:0] a_count;
  logic [3:0]  a_state;

  // instance B: 4-bit counter, halting trap
  logic        b_rst_n, b_mem_ready, b_zero;
  logic [5:0]  b_opcode, b_functi;
  logic        b_pc_write, b_pc_write_cond, b_pc_en, b_iord, b_ir_write, b_mem_write;
  logic [1:0]  b_m2r, b_rdst, b_alu_src_b, b_alu_op, b_pc_source;
  logic        b_register_write, b_alu_src_a, b_instr_done, b_illegal_op;
  logic [3:0]  b_count;
  logic [3:0]  b_state;

  mc_maindec dut_a (
    .clk(clk), .rst_n(a_rst_n), .opcode(a_opcode), .functi(a_functi),
    .mem_ready(a_mem_ready), .zero(a_zero), .pc_write(a_pc_write),
    .pc_write_cond(a_pc_write_cond), .pc_en(a_pc_en), .iord(a_iord),
    .ir_write(a_ir_write), .mem_write(a_mem_write), .memory_to_register(a_m2r),
    .register_destination(a_rdst), .register_write(a_register_write),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_operation(a_alu_op),
    .pc_source(a_pc_source), .instr_done(a_instr_done), .illegal_op(a_illegal_op),
    .instr_count(a_count), .state_o(a_state)
  );

  mc_maindec #(.CNT_W(4), .TRAP_HALT(1)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .opcode(b_opcode), .functi(b_functi),
    .mem_ready(b_mem_ready), .zero(b_zero), .pc_write(b_pc_write),
    .pc_write_cond(b_pc_write_cond), .pc_en(b_pc_en), .iord(b_iord),
    .ir_write(b_ir_write), .mem_write(b_mem_write), .memory_to_register(b_m2r),
    .register_destination(b_rdst), .register_write(b_register_write),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_operation(b_alu_op),
    .pc_source(b_pc_source), .instr_done(b_instr_done), .illegal_op(b_illegal_op),
    .instr_count(b_count), .state_o(b_state)
  );

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-instruction behaviour, taken from the instruction-level rules.
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       zero;
    int         cyc;    // cycles with memory always ready
    logic       trap;
    logic       rw;     // register_write on final cycle
    logic [1:0] rd;
    logic [1:0] m2r;
    logic [1:0] psrc;
    logic       pcen;
    logic [1:0] alu;    // alu_operation on the third cycle
  } vec_t;

  function automatic vec_t ref_vec(input logic [5:0] op, input logic [5:0] fn, input logic z);
    vec_t v;
    v = '{op, fn, z, 3, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0};
    case (op)
      6'd0: if (fn == 6'b001000) begin v.pcen = 1; v.psrc = 2'd3; end
            else begin v.cyc = 4; v.rw = 1; v.rd = 2'd1; v.alu = 2'd2; end
      6'd1: begin v.cyc = 5; v.rw = 1; v.m2r = 2'd1; end
      6'd2: v.cyc = 4;
      6'd3: begin v.cyc = 4; v.rw = 1; end
      6'd4: begin v.cyc = 4; v.rw = 1; v.alu = 2'd1; end
      6'd5: begin v.pcen = z; v.psrc = 2'd1; v.alu = 2'd1; end
      6'd7: begin v.pcen = 1; v.psrc = 2'd2; end
      6'd8: begin v.pcen = 1; v.psrc = 2'd2; v.rw = 1; v.rd = 2'd2; v.m2r = 2'd2; end
      default: v.trap = 1;
    endcase
    return v;
  endfunction

  // Runs one instruction on instance A. Step kinds: 0 fixed, 1 fetch wait,
  // 2 memory wait, 3 trap. Entered and left just after a rising edge.
  task automatic run_a(input vec_t v, input int stall, output int cyc);
    int kinds[$];
    int idx;
    bit last, adv;
    kinds = {1, 0};
    if (v.trap) kinds.push_back(3);
    else begin
      for (int i = 2; i < v.cyc; i++) kinds.push_back(0);
      if (v.op == 6'd1 || v.op == 6'd2) kinds[3] = 2;
    end
    a_opcode = v.op; a_functi = v.fn; a_zero = v.zero;
    idx = 0; cyc = 0;
    while (idx < kinds.size() && cyc < 200) begin
      a_mem_ready = ($urandom_range(0, 99) >= stall);
      @(negedge clk);
      cyc++;
      last = (idx == kinds.size() - 1);
      adv  = (kinds[idx] == 0) || (kinds[idx] == 3) || a_mem_ready;
      chk("instr_done", a_instr_done, last && adv && !v.trap);
      chk("illegal_op", a_illegal_op, kinds[idx] == 3);
      chk("instr_count", a_count, exp_cnt);
      chk("mem_write", a_mem_write, kinds[idx] == 2 && v.op == 6'd2);
      if (kinds[idx] == 1) begin
        chk("fetch_ir_write", a_ir_write, a_mem_ready);
        chk("fetch_pc_write", a_pc_write, a_mem_ready);
      end
      if (idx == 2) chk("alu_operation", a_alu_op, v.alu);
      if (last && adv) begin
        chk("register_write", a_register_write, v.rw);
        chk("register_destination", a_rdst, v.rd);
        chk("memory_to_register", a_m2r, v.m2r);
        chk("pc_source", a_pc_source, v.psrc);
        chk("pc_en", a_pc_en, v.pcen);
      end
      if (adv) begin
        if (last && !v.trap) exp_cnt++;
        idx++;
      end
      @(posedge clk); #1;
    end
    if (cyc >= 200) chk("instr_timeout", 32'(cyc), 32'd0);
  endtask

  vec_t tbl[11];
  logic [5:0] legal[8];
  vec_t v;
  int cyc, n;
  logic [5:0] rop, rfn;

  initial begin
    tbl = '{
      '{6'b000001, 6'd0,      1'b0, 5, 1'b0, 1'b1, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0},
      '{6'b000010, 6'd0,      1'b0, 4, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0},
      '{6'b000000, 6'b000111, 1'b0, 4, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 1'b0, 2'd2},
      '{6'b000000, 6'b001000, 1'b0, 3, 1'b0, 1'b0, 2'd0, 2'd0, 2'd3, 1'b1, 2'd0},
      '{6'b000011, 6'd0,      1'b0, 4, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0},
      '{6'b000100, 6'd5,      1'b1, 4, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 2'd1},
      '{6'b000101, 6'd0,      1'b1, 3, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 1'b1, 2'd1},
      '{6'b000101, 6'd0,      1'b0, 3, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 1'b0, 2'd1},
      '{6'b000111, 6'd0,      1'b0, 3, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b1, 2'd0},
      '{6'b001000, 6'd0,      1'b0, 3, 1'b0, 1'b1, 2'd2, 2'd2, 2'd2, 1'b1, 2'd0},
      '{6'b101010, 6'd0,      1'b0, 3, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0}
    };
    legal = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd7, 6'd8};

    a_rst_n = 0; a_mem_ready = 1; a_zero = 0; a_opcode = 0; a_functi = 0;
    b_rst_n = 0; b_mem_ready = 1; b_zero = 0; b_opcode = 0; b_functi = 0;

    // reset values while held, with mem_ready high
    #2;
    chk("rst_state", a_state, S_FETCH);
    chk("rst_ir_write", a_ir_write, 1'b0);
    chk("rst_pc_write", a_pc_write, 1'b0);
    chk("rst_pc_en", a_pc_en, 1'b0);
    chk("rst_count", a_count, 32'd0);
    chk("rst_alu_src_b", a_alu_src_b, 2'b01);
    chk("rst_iord", a_iord, 1'b0);
    repeat (2) @(posedge clk);
    #1 a_rst_n = 1; a_mem_ready = 0;

    // FETCH holds while memory is not ready
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_state", a_state, S_FETCH);
      chk("stall_ir_write", a_ir_write, 1'b0);
      chk("stall_pc_write", a_pc_write, 1'b0);
      @(posedge clk); #1;
    end
    a_mem_ready = 1;
    @(negedge clk);
    chk("ready_ir_write", a_ir_write, 1'b1);
    chk("ready_pc_write", a_pc_write, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_state", a_state, S_DECODE);
    @(posedge clk); #1 a_rst_n = 0;
    @(posedge clk); #1 a_rst_n = 1;
    exp_cnt = 0;

    // directed table, memory always ready
    for (int i = 0; i < 11; i++) begin
      run_a(tbl[i], 0, cyc);
      chk("latency", cyc, tbl[i].cyc);
      $display("instr op=%06b fn=%06b zero=%0d cycles=%0d count=%0d",
               tbl[i].op, tbl[i].fn, tbl[i].zero, cyc, a_count);
    end
    // same table with memory stalls
    for (int i = 0; i < 11; i++) begin
      run_a(tbl[i], 40, cyc);
      $display("instr op=%06b fn=%06b zero=%0d cycles=%0d count=%0d (stalled)",
               tbl[i].op, tbl[i].fn, tbl[i].zero, cyc, a_count);
    end
    // random instruction stream
    for (int i = 0; i < 150; i++) begin
      n = $urandom_range(0, 9);
      rop = (n < 8) ? legal[n] : 6'($urandom_range(0, 63));
      rfn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom_range(0, 63));
      v = ref_vec(rop, rfn, 1'($urandom_range(0, 1)));
      run_a(v, 30, cyc);
      $display("instr op=%06b fn=%06b zero=%0d cycles=%0d count=%0d",
               v.op, v.fn, v.zero, cyc, a_count);
    end

    // reset while a store is waiting on memory
    a_opcode = 6'b000010; a_mem_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1 a_mem_ready = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("memwr_state", a_state, S_MEMWR);
    chk("memwr_mem_write", a_mem_write, 1'b1);
    a_rst_n = 0;
    #1;
    chk("abort_mem_write", a_mem_write, 1'b0);
    chk("abort_state", a_state, S_FETCH);
    chk("abort_count", a_count, 32'd0);
    chk("abort_instr_done", a_instr_done, 1'b0);
    $display("instr abort store mid-MEMWR count=%0d", a_count);

    // halting trap on instance B
    b_opcode = 6'b101010; b_mem_ready = 1;
    @(posedge clk); #1 b_rst_n = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("halt_state", b_state, S_TRAP);
      chk("halt_illegal", b_illegal_op, 1'b1);
      chk("halt_count", b_count, 4'd0);
      chk("halt_pc_write", b_pc_write, 1'b0);
      @(posedge clk); #1;
    end
    b_rst_n = 0;
    #1;
    chk("halt_released", b_illegal_op, 1'b0);
    chk("halt_rst_state", b_state, S_FETCH);
    $display("instr trap halt held 12 cycles on instance B");

    // 17 jumps on a 4-bit counter wrap it to 1
    b_opcode = 6'b000111;
    @(posedge clk); #1 b_rst_n = 1;
    n = 0;
    for (int c = 0; c < 200 && n < 17; c++) begin
      @(negedge clk);
      if (b_instr_done) n++;
    end
    chk("jump_pulses", n, 17);
    @(posedge clk); #1;
    chk("count_wrap", b_count, 4'd1);
    $display("instr 17 jumps count=%0d", b_count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
